// File: rtl/panel_text_scheduler.sv
// panel_text_scheduler: round-robin text source arbiter with frame-synchronous panel string commit
// Ports:
//   vga_clk_i     pixel clock, all logic on rising edge
//   rst_i         synchronous active-high reset
//   req_i         level request per source
//   msg_i         flattened messages, source i at [i*8*CHAR_COUNT +: 8*CHAR_COUNT], char 0 MSB
//   frame_start_i one-cycle pulse at frame start
//   grant_o       one-hot pulse when a source's message is captured
//   ack_o         one-hot pulse when that source's text becomes visible
//   string_o      panel text, char k at [8*(CHAR_COUNT-k)-1 -: 8], upper bits zero
//   cur_src_o     source whose text is displayed
//   busy_o        high outside IDLE
module panel_text_scheduler #(
    parameter int          NUM_REQ    = 3,
    parameter int          CHAR_COUNT = 13,
    parameter int          STR_BITS   = 400,
    parameter logic [7:0]  PAD_CHAR   = 8'h20,
    parameter logic [7:0]  BAD_CHAR   = 8'h3F
) (
    input  logic                            vga_clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*8*CHAR_COUNT-1:0] msg_i,
    input  logic                            frame_start_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic [STR_BITS-1:0]             string_o,
    output logic [1:0]                      cur_src_o,
    output logic                            busy_o
);
    localparam int W = 8 * CHAR_COUNT;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_FRAME, COMMIT} state_t;

    state_t             state_q;
    logic [1:0]         last_q, sel_q, sel_d, j;
    logic [W-1:0]       msg_q, shadow_q, str_q;
    logic [3:0]         idx_q;
    logic               nul_q;
    logic [7:0]         c, wc;
    logic [NUM_REQ-1:0] grant_q, ack_q;
    logic [1:0]         cur_src_q;
    int                 off;

    // Scan from the farthest candidate down so the nearest requester after last_q wins.
    always_comb begin
        sel_d = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = 2'((int'(last_q) + k) % NUM_REQ);
            if (req_i[j]) sel_d = j;
        end
    end

    // Once a NUL is seen, every remaining char becomes padding.
    always_comb begin
        off = 8 * (CHAR_COUNT - 1 - int'(idx_q));
        c = msg_q[off +: 8];
        wc = (nul_q || c == 8'h00) ? PAD_CHAR : (c < 8'h20 || c > 8'h7E) ? BAD_CHAR : c;
    end

    always_ff @(posedge vga_clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= 2'(NUM_REQ - 1);
            sel_q     <= '0;
            msg_q     <= '0;
            idx_q     <= '0;
            nul_q     <= 1'b0;
            shadow_q  <= {CHAR_COUNT{PAD_CHAR}};
            str_q     <= {CHAR_COUNT{PAD_CHAR}};
            grant_q   <= '0;
            ack_q     <= '0;
            cur_src_q <= '0;
        end else begin
            grant_q <= '0;
            ack_q   <= '0;
            case (state_q)
                IDLE: if (|req_i) begin
                    grant_q <= NUM_REQ'(1) << sel_d;
                    msg_q   <= msg_i[int'(sel_d)*W +: W];
                    sel_q   <= sel_d;
                    idx_q   <= '0;
                    nul_q   <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    shadow_q[off +: 8] <= wc;
                    nul_q <= nul_q || c == 8'h00;
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'(CHAR_COUNT - 1)) state_q <= WAIT_FRAME;
                end
                WAIT_FRAME: if (frame_start_i) state_q <= COMMIT;
                default: begin
                    str_q     <= shadow_q;
                    cur_src_q <= sel_q;
                    ack_q     <= NUM_REQ'(1) << sel_q;
                    last_q    <= sel_q;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign ack_o     = ack_q;
    assign string_o  = STR_BITS'(str_q);
    assign cur_src_o = cur_src_q;
    assign busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_panel_text_scheduler.sv
// tb_panel_text_scheduler: directed self-checking bench for panel_text_scheduler
module tb_panel_text_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = '0;
    logic [311:0] msg = '0;
    logic         frame_start = 1'b0;
    logic [2:0]   grant, ack;
    logic [399:0] str;
    logic [1:0]   cur_src;
    logic         busy;
    int           total = 0;
    int           bad = 0;

    localparam logic [103:0] M0   = {"HELLO", 8'h00, "XYZ", 32'h0};
    localparam logic [103:0] M1   = {"AB", 8'h07, "~ ", 8'h80, "EFGHIJK"};
    localparam logic [103:0] M2   = {8'h1F, 8'h7F, "score 12345"};
    localparam logic [103:0] E0   = "HELLO        ";
    localparam logic [103:0] E1   = "AB?~ ?EFGHIJK";
    localparam logic [103:0] E2   = "??score 12345";
    localparam logic [103:0] SPC  = {13{8'h20}};

    panel_text_scheduler dut (
        .vga_clk_i(clk), .rst_i(rst), .req_i(req), .msg_i(msg),
        .frame_start_i(frame_start), .grant_o(grant), .ack_o(ack),
        .string_o(str), .cur_src_o(cur_src), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_grant(input int s);
        tick();
        chk("grant", 400'(grant), 400'(3'b001 << s));
        chk("busy_load", 400'(busy), 400'(1'b1));
        chk("ack_idle", 400'(ack), 400'(0));
    endtask

    // Pulse frame_start during LOAD (must be ignored), wait w cycles in WAIT_FRAME, then commit.
    task automatic do_commit(input int s, input logic [103:0] exp, input logic [103:0] prev, input int w);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (12) tick();
        chk("busy_wait", 400'(busy), 400'(1'b1));
        repeat (w) tick();
        chk("ack_wait", 400'(ack), 400'(0));
        chk("str_hold", str, 400'(prev));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("str_commit_cyc", str, 400'(prev));
        chk("ack_commit_cyc", 400'(ack), 400'(0));
        tick();
        chk("ack", 400'(ack), 400'(3'b001 << s));
        chk("string", str, 400'(exp));
        chk("cur_src", 400'(cur_src), 400'(s));
    endtask

    initial begin
        msg = {M2, M1, M0};
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_string", str, 400'(SPC));
        chk("rst_busy", 400'(busy), 400'(0));
        chk("rst_grant", 400'(grant), 400'(0));
        chk("rst_ack", 400'(ack), 400'(0));
        chk("rst_cur_src", 400'(cur_src), 400'(0));

        // single request; requester drops req and changes msg after grant
        req = 3'b001;
        do_grant(0);
        req = 3'b000;
        msg[103:0] = "GARBAGE12345X";
        do_commit(0, E0, SPC, 5);
        tick();
        chk("ack_one_cycle", 400'(ack), 400'(0));
        chk("idle_busy", 400'(busy), 400'(0));
        chk("grant_none", 400'(grant), 400'(0));

        // round robin from reset with all sources requesting
        msg = {M2, M1, M0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_string", str, 400'(SPC));
        req = 3'b111;
        do_grant(0);
        do_commit(0, E0, SPC, 30);
        do_grant(1);
        do_commit(1, E1, E0, 3);
        do_grant(2);
        do_commit(2, E2, E1, 0);
        do_grant(0);
        do_commit(0, E0, E2, 7);

        // reset while waiting for a frame aborts with no ack
        req = 3'b010;
        do_grant(1);
        req = 3'b000;
        repeat (15) tick();
        chk("wait_busy", 400'(busy), 400'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ack", 400'(ack), 400'(0));
        chk("abort_busy", 400'(busy), 400'(0));
        chk("abort_string", str, 400'(SPC));
        chk("abort_cur_src", 400'(cur_src), 400'(0));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("abort_no_ack", 400'(ack), 400'(0));
        chk("abort_str_hold", str, 400'(SPC));
        req = 3'b011;
        do_grant(0);
        req = 3'b000;
        do_commit(0, E0, SPC, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
